spi_txn_sched: RTL and testbench
================================

SPI_TXN_SCHED -- requirements
Module: spi_txn_sched

Interface
REQ-001 Parameter CMD_WIDTH, default 5: command field width, {rw, addr}.
REQ-002 Parameter ADDR_WIDTH, default 4: address width; the rw bit is CMD_WIDTH-ADDR_WIDTH = 1 bit.
REQ-003 Parameter DATA_WIDTH, default 11: data field width.
REQ-004 Parameter CLK_DIV, default 2 (>=1): clk cycles per sclk half-period.
REQ-005 Parameters CS_SU_CYC / CS_HD_CYC / CS_HI_CYC, defaults 2 / 2 / 8 (>=1): CS setup, CS hold and minimum CS-high time, in clk cycles.
REQ-006 Ports: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 Ports: reqN_valid  in  1, reqN_ready  out  1, reqN_rw  in  1 (0=WRITE, 1=READ), reqN_addr  in  ADDR_WIDTH, reqN_wdata  in  DATA_WIDTH; N = 0, 1.
REQ-008 Ports: rsp_valid  out  1  completion pulse; rsp_id  out  1  requester index; rsp_rdata  out  DATA_WIDTH  captured MISO data.
REQ-009 Ports: spi_cs_n, spi_sclk, spi_mosi  out  1; spi_miso  in  1; busy  out  1, high whenever state is not IDLE.

Function
REQ-010 One clk domain: clk. Reset is asynchronous, active-low: rst_n.
REQ-011 FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-012 Handshake: a transfer occurs on valid&ready. reqN_ready is high only in IDLE, only for the granted requester, and only while that requester's valid is high.
REQ-013 A requester holds valid and its payload stable until ready is seen; the payload is latched on the handshake.
REQ-014 Arbitration: round-robin. With only one valid, that one is granted. With both valid, the requester not granted last is granted. After reset, last-granted = 1, so req0 wins first.
REQ-015 Handshake -> SETUP. spi_cs_n goes low on the next clk edge (latency 1). SETUP lasts CS_SU_CYC cycles, with sclk low.
REQ-016 SHIFT sends the frame {rw, addr, wdata}, 16 bits, MSB first.
REQ-017 Each SHIFT bit is CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high.
REQ-018 spi_mosi takes the current bit on the edge that drives sclk high, and holds it until the next bit's rising edge.
REQ-019 spi_miso is sampled on the clk edge that drives sclk low and is shifted into a 16-bit register.
REQ-020 rsp_rdata = the last DATA_WIDTH sampled bits; the first CMD_WIDTH samples are discarded. Capture happens for both read and write.
REQ-021 After the 16th falling sclk edge -> HOLD: cs_n low, sclk low, mosi 0, for CS_HD_CYC cycles.
REQ-022 HOLD -> GAP: cs_n high on entry. rsp_valid pulses for exactly one cycle on that same entry cycle, with rsp_id and rsp_rdata valid. rsp_rdata holds its value until the next pulse.
REQ-023 GAP lasts CS_HI_CYC cycles, then -> IDLE. No handshake is accepted during GAP, so back-to-back frames always have cs_n high for >= CS_HI_CYC cycles.
REQ-024 Frame length: cs_n low for CS_SU_CYC + 32*CLK_DIV + CS_HD_CYC cycles.
REQ-025 A request that becomes valid during a transaction waits; no request is dropped or reordered within a requester.
REQ-026 Counters: divider ceil(log2(CLK_DIV+1)) bits; bit counter 5 bits; wait counter sized for max(CS_SU_CYC, CS_HD_CYC, CS_HI_CYC). No counter wraps within a state.

Reset
REQ-027 Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, all reqN_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, busy=0, state=IDLE, last-granted=1.
REQ-028 Reset asserted mid-transaction takes effect immediately without a clock: cs_n high, sclk low. The transaction is discarded, with no rsp_valid. After release, a new request is accepted normally, with no GAP enforced.

Structure
REQ-029 A shared package spi_sim_pkg holds: the WRITE/READ encodings; the FSM state enum; default width constants (5/4/11); default timing constants.
REQ-030 One sub-module, spi_rr_arb2: 2-way round-robin grant with a last-grant register, updated on handshake.
REQ-031 The shift engine and FSM stay in spi_txn_sched.

Verification
REQ-032 Single write: req0 rw=0, addr=0x5, wdata=0x2A5, defaults -> MOSI bits 0_0101_01010100101; cs_n low 68 cycles; one rsp_valid with rsp_id=0.
REQ-033 Read: req1 rw=1, addr=0xA; slave model drives 0x5A3 in the data phase -> rsp_rdata=0x5A3, rsp_id=1; MOSI cmd bits 1_1010.
REQ-034 Both valid in the same cycle after reset -> req0 served, then req1. A second simultaneous pair -> again alternating, starting with the requester not last granted.
REQ-035 req0 held valid continuously for 3 frames -> cs_n high for >= 8 cycles between frames; ready is never high outside IDLE.
REQ-036 rst_n low during SHIFT bit 7 -> cs_n=1 and sclk=0 in the same timestep; no rsp_valid. After release, req0 write addr=0xF completes normally.
REQ-037 Protocol checker: mosi stable across every sclk falling edge; sclk low whenever cs_n is high; rsp_valid is never asserted for two consecutive cycles.

Source files
------------

// File: rtl/spi_sim_pkg.sv
// ---------------------------------------------------------------------------
// spi_sim_pkg
// Shared definitions for the SPI transaction scheduler slice.
//   - rw bit encodings (WRITE / READ)
//   - FSM state enumeration used by spi_txn_sched
//   - default field widths and default CS timing values
//   - max3(): helper used to size the shared wait counter
// ---------------------------------------------------------------------------
package spi_sim_pkg;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   localparam int DEF_CMD_WIDTH  = 5;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 11;

   localparam int DEF_CLK_DIV   = 2;
   localparam int DEF_CS_SU_CYC = 2;
   localparam int DEF_CS_HD_CYC = 2;
   localparam int DEF_CS_HI_CYC = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   // Largest of three timing values; the single wait counter is reused by
   // SETUP, HOLD and GAP, so it has to cover whichever of them is longest.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// ---------------------------------------------------------------------------
// spi_rr_arb2
// Two-way round-robin arbiter with a last-grant register.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset (last-grant resets to 1)
//   req_valid  in   [1:0] request valid, bit N = requester N
//   accept     in   pulse: the currently granted request was accepted
//   grant      out  index of the requester currently granted
// ---------------------------------------------------------------------------
module spi_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_valid,
   input  logic       accept,
   output logic       grant
);

   logic last_q;
   logic last_d;

   // A lone requester always wins. When both (or neither) are asking, the
   // one that was not served last gets the grant, which makes requester 0
   // the first winner out of reset.
   always_comb begin
      grant = ~last_q;
      case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         default: grant = ~last_q;
      endcase
   end

   // The fairness pointer only advances when a grant actually turns into a
   // transfer, so an idle or withdrawn grant does not skip anyone's turn.
   always_comb begin
      last_d = last_q;
      if (accept) begin
         last_d = grant;
      end
   end

   // Last-grant register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/spi_txn_sched.sv
// ---------------------------------------------------------------------------
// spi_txn_sched
// Two-requester SPI master transaction scheduler. Each accepted request is
// sent as one frame {rw, addr, wdata}, MSB first, SPI mode 0 style timing
// with programmable CS setup / hold / minimum-high times.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake, N = 0, 1
//   reqN_rw, reqN_addr,
//   reqN_wdata                 request payload (rw: 0 = write, 1 = read)
//   rsp_valid                  one-cycle completion pulse
//   rsp_id                     index of the requester that completed
//   rsp_rdata                  last DATA_WIDTH bits sampled from MISO
//   spi_cs_n, spi_sclk,
//   spi_mosi, spi_miso         SPI bus
//   busy                       high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module spi_txn_sched
   import spi_sim_pkg::*;
#(
   parameter int CMD_WIDTH  = DEF_CMD_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int CS_SU_CYC  = DEF_CS_SU_CYC,
   parameter int CS_HD_CYC  = DEF_CS_HD_CYC,
   parameter int CS_HI_CYC  = DEF_CS_HI_CYC
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_rw,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_rw,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,

   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_rdata,

   output logic                  spi_cs_n,
   output logic                  spi_sclk,
   output logic                  spi_mosi,
   input  logic                  spi_miso,

   output logic                  busy
);

   localparam int FRAME_W  = CMD_WIDTH + DATA_WIDTH;
   localparam int DIV_W    = $clog2(CLK_DIV + 1);
   localparam int WAIT_MAX = max3(CS_SU_CYC, CS_HD_CYC, CS_HI_CYC);
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [4:0]        BIT_LAST   = 5'(FRAME_W - 1);
   localparam logic [WAIT_W-1:0] SU_LAST    = WAIT_W'(CS_SU_CYC - 1);
   localparam logic [WAIT_W-1:0] HD_LAST    = WAIT_W'(CS_HD_CYC - 1);
   localparam logic [WAIT_W-1:0] HI_LAST    = WAIT_W'(CS_HI_CYC - 1);

   spi_state_e            state_q,     state_d;
   logic [DIV_W-1:0]      div_cnt_q,   div_cnt_d;
   logic [4:0]            bit_cnt_q,   bit_cnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q,  wait_cnt_d;
   logic [FRAME_W-1:0]    tx_q,        tx_d;
   logic [DATA_WIDTH-1:0] rx_q,        rx_d;
   logic                  id_q,        id_d;
   logic                  cs_n_q,      cs_n_d;
   logic                  sclk_q,      sclk_d;
   logic                  mosi_q,      mosi_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_id_q,    rsp_id_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic grant;
   logic accept;

   spi_rr_arb2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid ({req1_valid, req0_valid}),
      .accept    (accept),
      .grant     (grant)
   );

   // Ready is offered only in IDLE, only to the granted requester and only
   // while it is asking; accept is the resulting valid&ready transfer.
   always_comb begin
      req0_ready = (state_q == ST_IDLE) && !grant && req0_valid;
      req1_ready = (state_q == ST_IDLE) &&  grant && req1_valid;
      accept     = req0_ready || req1_ready;
   end

   // Next-state and datapath logic. Every bus output is a flop, so the
   // values chosen here appear on the pins one clk later. In SHIFT the
   // divider counts CLK_DIV cycles per sclk half; the rising half-edge
   // launches the next MOSI bit and the falling half-edge samples MISO.
   // Only the last DATA_WIDTH samples are kept: the command-phase samples
   // simply shift out of the top of rx.
   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      id_d        = id_q;
      cs_n_d      = cs_n_q;
      sclk_d      = sclk_q;
      mosi_d      = mosi_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d    = ST_SETUP;
               cs_n_d     = 1'b0;
               sclk_d     = 1'b0;
               mosi_d     = 1'b0;
               wait_cnt_d = '0;
               id_d       = grant;
               tx_d       = grant ? {req1_rw, req1_addr, req1_wdata}
                                  : {req0_rw, req0_addr, req0_wdata};
            end
         end

         ST_SETUP: begin
            if (wait_cnt_q == SU_LAST) begin
               state_d    = ST_SHIFT;
               wait_cnt_d = '0;
               div_cnt_d  = '0;
               bit_cnt_d  = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         ST_SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  mosi_d = tx_q[FRAME_W-1];
                  tx_d   = {tx_q[FRAME_W-2:0], 1'b0};
               end else begin
                  sclk_d = 1'b0;
                  rx_d   = {rx_q[DATA_WIDTH-2:0], spi_miso};
                  if (bit_cnt_q == BIT_LAST) begin
                     state_d    = ST_HOLD;
                     wait_cnt_d = '0;
                     mosi_d     = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end

         ST_HOLD: begin
            if (wait_cnt_q == HD_LAST) begin
               state_d     = ST_GAP;
               wait_cnt_d  = '0;
               cs_n_d      = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_rdata_d = rx_q;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         ST_GAP: begin
            if (wait_cnt_q == HI_LAST) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers. Reset is asynchronous so an abort in the
   // middle of a frame releases CS and parks SCLK immediately; the partial
   // frame is dropped and the FSM restarts in IDLE without a GAP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         id_q        <= 1'b0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         id_q        <= id_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Registered outputs to the pins.
   always_comb begin
      spi_cs_n  = cs_n_q;
      spi_sclk  = sclk_q;
      spi_mosi  = mosi_q;
      rsp_valid = rsp_valid_q;
      rsp_id    = rsp_id_q;
      rsp_rdata = rsp_rdata_q;
      busy      = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_spi_txn_sched.sv
// ---------------------------------------------------------------------------
// tb_spi_txn_sched
// Self-checking bench for spi_txn_sched with default parameters. A table of
// single transactions is applied in a loop, followed by hand-written
// sequences for arbitration, back-to-back frames and mid-frame reset.
// A SPI slave model drives MISO; a monitor tracks CS timing, collects the
// MOSI frame and checks bus protocol every cycle.
// ---------------------------------------------------------------------------
module tb_spi_txn_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req0_valid = 1'b0, req0_rw = 1'b0;
   logic [3:0]  req0_addr = '0;
   logic [10:0] req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_rw = 1'b0;
   logic [3:0]  req1_addr = '0;
   logic [10:0] req1_wdata = '0;
   logic        req0_ready, req1_ready;
   logic        rsp_valid, rsp_id;
   logic [10:0] rsp_rdata;
   logic        spi_cs_n, spi_sclk, spi_mosi, busy;
   logic        spi_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          id;
      logic        rw;
      logic [3:0]  addr;
      logic [10:0] wdata;
      logic [15:0] slave;
      logic [15:0] exp_frame;
      logic [10:0] exp_rdata;
   } vec_t;

   vec_t vecs[5];

   spi_txn_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_rw    (req0_rw),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_rw    (req1_rw),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_rdata  (rsp_rdata),
      .spi_cs_n   (spi_cs_n),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .busy       (busy)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Stop runaway simulations with a visible failure.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave model: presents the next bit of slave_word on each rising SCLK,
   // MSB first, restarting at every CS assertion.
   logic [15:0] slave_word = '0;
   int          slave_idx = 0;

   always @(negedge spi_cs_n) slave_idx = 0;

   always @(posedge spi_sclk) begin
      if (slave_idx < 16) spi_miso = slave_word[15 - slave_idx];
      slave_idx++;
   end

   // Monitor, sampled on falling clk: CS run lengths, MOSI frame capture,
   // response capture and continuous protocol checks.
   logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
   logic        prev_rv = 1'b0;
   int          low_run = 0, high_run = 0, last_low = 0, min_gap = 1000;
   int          falls = 0, rsp_count = 0;
   logic [15:0] mosi_cap = '0, last_frame = '0;
   logic        last_id = 1'b0;
   logic [10:0] last_rdata = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("sclk_low_while_cs_high", {31'd0, spi_cs_n & spi_sclk}, 32'd0);
         checkOutput("rsp_valid_single_cycle", {31'd0, rsp_valid & prev_rv}, 32'd0);
         checkOutput("ready_only_in_idle",
                     {31'd0, busy & (req0_ready | req1_ready)}, 32'd0);
      end
      if (spi_cs_n != prev_cs) begin
         if (!spi_cs_n) begin
            if (high_run < min_gap) min_gap = high_run;
            low_run  = 0;
            falls    = 0;
            mosi_cap = '0;
         end else begin
            last_low = low_run;
            high_run = 0;
         end
      end
      if (!spi_cs_n) low_run++;
      else high_run++;
      if (rst_n && prev_sclk && !spi_sclk) begin
         falls++;
         mosi_cap = {mosi_cap[14:0], prev_mosi};
         if (falls == 16) checkOutput("mosi_zero_in_hold", {31'd0, spi_mosi}, 32'd0);
         else checkOutput("mosi_stable_on_fall", {31'd0, spi_mosi}, {31'd0, prev_mosi});
      end
      if (rst_n && rsp_valid) begin
         rsp_count++;
         last_id    = rsp_id;
         last_rdata = rsp_rdata;
         last_frame = mosi_cap;
      end
      prev_cs   = spi_cs_n;
      prev_sclk = spi_sclk;
      prev_mosi = spi_mosi;
      prev_rv   = rsp_valid;
   end

   // Main-thread step: one cycle later, just after the monitor has run.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic driveReq(input int id, input logic rw, input logic [3:0] addr,
                           input logic [10:0] wdata);
      if (id == 0) begin
         req0_rw = rw; req0_addr = addr; req0_wdata = wdata; req0_valid = 1'b1;
      end else begin
         req1_rw = rw; req1_addr = addr; req1_wdata = wdata; req1_valid = 1'b1;
      end
   endtask

   task automatic waitAccept(input int id);
      bit ok;
      ok = 0;
      #1;
      for (int c = 0; c < 400; c++) begin
         if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
            ok = 1;
            tick();
            if (id == 0) req0_valid = 1'b0;
            else req1_valid = 1'b0;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++; errors++;
         $display("[TB] FAIL accept_timeout: requester %0d got no ready, required ready within 400 cycles", id);
      end
   endtask

   task automatic waitRsp(input int base);
      bit ok;
      ok = 0;
      for (int c = 0; c < 400; c++) begin
         if (rsp_count > base) begin ok = 1; break; end
         tick();
      end
      if (!ok) begin
         checks++; errors++;
         $display("[TB] FAIL rsp_timeout: rsp count %0d, required more than %0d", rsp_count, base);
      end
   endtask

   task automatic waitIdle();
      for (int c = 0; c < 400 && busy; c++) tick();
      checkOutput("returns_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic applyStimulus(input vec_t v);
      int base;
      base = rsp_count;
      slave_word = v.slave;
      driveReq(v.id, v.rw, v.addr, v.wdata);
      waitAccept(v.id);
      waitRsp(base);
      checkOutput("vec_rsp_count", rsp_count - base, 32'd1);
      checkOutput("vec_rsp_id", {31'd0, last_id}, v.id);
      checkOutput("vec_rsp_rdata", {21'd0, last_rdata}, {21'd0, v.exp_rdata});
      checkOutput("vec_mosi_frame", {16'd0, last_frame}, {16'd0, v.exp_frame});
      checkOutput("vec_cs_low_cycles", last_low, 32'd68);
      waitIdle();
   endtask

   initial begin
      int base, accepts;

      vecs[0] = '{0, 1'b0, 4'h5, 11'h2A5, 16'h0123, 16'h2AA5, 11'h123};
      vecs[1] = '{1, 1'b1, 4'hA, 11'h000, 16'h05A3, 16'hD000, 11'h5A3};
      vecs[2] = '{0, 1'b1, 4'hF, 11'h7FF, 16'hFFFF, 16'hFFFF, 11'h7FF};
      vecs[3] = '{1, 1'b0, 4'h0, 11'h001, 16'hF800, 16'h0001, 11'h000};
      vecs[4] = '{0, 1'b0, 4'h3, 11'h400, 16'h0001, 16'h1C00, 11'h001};

      #1 rst_n = 1'b0;
      tick();
      tick();
      checkOutput("reset_cs_n", {31'd0, spi_cs_n}, 32'd1);
      checkOutput("reset_sclk", {31'd0, spi_sclk}, 32'd0);
      checkOutput("reset_mosi", {31'd0, spi_mosi}, 32'd0);
      checkOutput("reset_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
      checkOutput("reset_rsp_rdata", {21'd0, rsp_rdata}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

      $display("[TB] simultaneous requests after reset");
      doReset();
      slave_word = 16'h0000;
      base = rsp_count;
      driveReq(0, 1'b0, 4'h1, 11'h011);
      driveReq(1, 1'b0, 4'h2, 11'h022);
      #1;
      checkOutput("pair1_ready0", {31'd0, req0_ready}, 32'd1);
      checkOutput("pair1_ready1", {31'd0, req1_ready}, 32'd0);
      waitAccept(0);
      waitRsp(base);
      checkOutput("pair1_first_id", {31'd0, last_id}, 32'd0);
      waitAccept(1);
      waitRsp(base + 1);
      checkOutput("pair1_second_id", {31'd0, last_id}, 32'd1);
      checkOutput("pair1_second_frame", {16'd0, last_frame}, 32'h1022);
      waitIdle();

      base = rsp_count;
      driveReq(0, 1'b0, 4'h4, 11'h044);
      waitAccept(0);
      waitRsp(base);
      waitIdle();

      base = rsp_count;
      driveReq(0, 1'b0, 4'h1, 11'h011);
      driveReq(1, 1'b0, 4'h2, 11'h022);
      #1;
      checkOutput("pair2_ready0", {31'd0, req0_ready}, 32'd0);
      checkOutput("pair2_ready1", {31'd0, req1_ready}, 32'd1);
      waitAccept(1);
      waitRsp(base);
      checkOutput("pair2_first_id", {31'd0, last_id}, 32'd1);
      waitAccept(0);
      waitRsp(base + 1);
      checkOutput("pair2_second_id", {31'd0, last_id}, 32'd0);
      checkOutput("pair2_second_frame", {16'd0, last_frame}, 32'h0811);
      waitIdle();

      $display("[TB] req0 held valid for three frames");
      min_gap = 1000;
      base = rsp_count;
      accepts = 0;
      driveReq(0, 1'b0, 4'h7, 11'h0F0);
      #1;
      for (int c = 0; c < 1000; c++) begin
         if (req0_ready) begin
            accepts++;
            if (accepts == 3) begin
               tick();
               req0_valid = 1'b0;
               break;
            end
         end
         tick();
      end
      checkOutput("b2b_accepts", accepts, 32'd3);
      waitRsp(base + 2);
      checkOutput("b2b_rsp_count", rsp_count - base, 32'd3);
      checkOutput("b2b_last_id", {31'd0, last_id}, 32'd0);
      checkOutput("b2b_cs_high_gap_ge_8", {31'd0, min_gap >= 8}, 32'd1);
      waitIdle();

      $display("[TB] reset during bit 7");
      base = rsp_count;
      slave_word = 16'h0ABC;
      driveReq(0, 1'b0, 4'h2, 11'h333);
      waitAccept(0);
      for (int c = 0; c < 400; c++) begin
         if (falls == 7 && spi_sclk) break;
         tick();
      end
      checkOutput("abort_reached_bit7", {31'd0, spi_sclk}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_cs_n_immediate", {31'd0, spi_cs_n}, 32'd1);
      checkOutput("abort_sclk_immediate", {31'd0, spi_sclk}, 32'd0);
      tick();
      tick();
      tick();
      checkOutput("abort_no_rsp", rsp_count - base, 32'd0);
      rst_n = 1'b1;
      tick();
      driveReq(0, 1'b0, 4'hF, 11'h155);
      #1;
      checkOutput("abort_ready_no_gap", {31'd0, req0_ready}, 32'd1);
      waitAccept(0);
      waitRsp(base);
      checkOutput("abort_after_rsp_id", {31'd0, last_id}, 32'd0);
      checkOutput("abort_after_frame", {16'd0, last_frame}, 32'h7955);
      checkOutput("abort_after_rdata", {21'd0, last_rdata}, 32'h2BC);
      checkOutput("abort_after_cs_low", last_low, 32'd68);
      waitIdle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
